alu_sequencer: RTL and testbench

Instruction sequencer for the 8-bit processor: fetches opcode bytes from program memory, owns the accumulator (ACC), EXT register, CB flag and a 16×8 register file, and issues `{ACC, Ri, Opcode}` to the combinational ALU. It captures `Result`, `CB` and `EXT` back into architectural state. It sits between program memory and the ALU and is the opcode producer for the ALU's consumer.

---
 rtl/alu_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit processor: fetches opcodes, owns ACC/EXT/CB and the
// register file, and feeds the combinational ALU.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       imem_rd,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] alu_acc,
    output logic [7:0] alu_ri,
    output logic [7:0] alu_opcode,
    input  logic [7:0] alu_result,
    input  logic       alu_cb,
    input  logic [7:0] alu_ext,
    output logic       busy,
    output logic       halted,
    output logic [7:0] acc_out,
    output logic [7:0] ext_out,
    output logic       cb_out,
    output logic [7:0] pc_out
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StFetchImm,
        StLoadImm,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] ext_q, ext_d;
    logic       cb_q, cb_d;
    logic [7:0] rf_q [16];
    logic       rf_we;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        ext_d      = ext_q;
        cb_d       = cb_q;
        rf_we      = 1'b0;
        imem_rd    = 1'b0;
        alu_opcode = 8'h00;

        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d    = 8'h00;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                imem_rd = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                ir_d = imem_data;
                pc_d = pc_q + 8'd1;
                if (imem_data == 8'hFF) begin
                    state_d = StHalt;
                end else if (imem_data[7:4] == 4'hA) begin
                    state_d = StFetchImm;
                end else begin
                    state_d = StExec;
                end
            end
            StFetchImm: begin
                imem_rd = 1'b1;
                state_d = StLoadImm;
            end
            StLoadImm: begin
                acc_d   = imem_data;
                pc_d    = pc_q + 8'd1;
                state_d = StFetch;
            end
            StExec: begin
                alu_opcode = ir_q;
                state_d    = StFetch;
                // Writeback is committed on the edge that leaves EXEC.
                case (ir_q[7:4])
                    4'h1, 4'h2, 4'h5, 4'h6: begin
                        acc_d = alu_result;
                        cb_d  = alu_cb;
                    end
                    4'h3: begin
                        acc_d = alu_result;
                        ext_d = alu_ext;
                        cb_d  = alu_cb;
                    end
                    4'h7: cb_d = alu_cb;
                    4'h8: rf_we = 1'b1;
                    4'h9: acc_d = alu_ri;
                    4'h0: begin
                        if (ir_q[3:0] inside {4'h1, 4'h2, 4'h6, 4'h7}) begin
                            acc_d = alu_result;
                            cb_d  = alu_cb;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            acc_q   <= 8'h00;
            ext_q   <= 8'h00;
            cb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
            cb_q    <= cb_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else if (rf_we) begin
            rf_q[ir_q[3:0]] <= acc_q;
        end
    end

    assign imem_addr = pc_q;
    assign alu_acc   = acc_q;
    assign alu_ri    = rf_q[ir_q[3:0]];
    assign busy      = (state_q != StIdle) && (state_q != StHalt);
    assign halted    = (state_q == StHalt);
    assign acc_out   = acc_q;
    assign ext_out   = ext_q;
    assign cb_out    = cb_q;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: program memory and ALU stubs plus an instruction-level reference
// interpreter; directed programs from the test plan followed by random programs.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       imem_rd;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] alu_acc;
    logic [7:0] alu_ri;
    logic [7:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_cb;
    logic [7:0] alu_ext;
    logic       busy;
    logic       halted;
    logic [7:0] acc_out;
    logic [7:0] ext_out;
    logic       cb_out;
    logic [7:0] pc_out;

    alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_rd   (imem_rd),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .alu_acc   (alu_acc),
        .alu_ri    (alu_ri),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .alu_cb    (alu_cb),
        .alu_ext   (alu_ext),
        .busy      (busy),
        .halted    (halted),
        .acc_out   (acc_out),
        .ext_out   (ext_out),
        .cb_out    (cb_out),
        .pc_out    (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] mem [256];
    int         wptr;

    // Reference architectural state.
    logic [7:0] m_acc, m_ext, m_pc;
    logic       m_cb;
    logic [7:0] m_r [16];

    logic [3:0] hi_tab [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};

    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    // Stub ALU; non-MUL ops drive a nonzero EXT and odd defaults so stray writes show up.
    function automatic logic [16:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0]  w;
        logic [15:0] p;
        logic        c;
        logic [7:0]  e, r;
        w = '0;
        p = '0;
        e = a ^ b ^ 8'hC3;
        r = ~a;
        c = 1'b1;
        case (op[7:4])
            4'h1: begin w = {1'b0, a} + {1'b0, b}; {c, r} = w; end
            4'h2, 4'h7: begin w = {1'b0, a} - {1'b0, b}; {c, r} = w; end
            4'h3: begin p = {8'h00, a} * {8'h00, b}; {e, r} = p; c = |p[15:8]; end
            4'h5: begin r = a & b; c = ^(a & b); end
            4'h6: begin r = a ^ b; c = a[0]; end
            4'h0: begin
                case (op[3:0])
                    4'h1: begin r = {a[6:0], 1'b0}; c = a[7]; end
                    4'h2: begin r = {1'b0, a[7:1]}; c = a[0]; end
                    4'h6: begin w = {1'b0, a} + 9'd1; {c, r} = w; end
                    4'h7: begin w = {1'b0, a} - 9'd1; {c, r} = w; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return {c, e, r};
    endfunction

    always_comb {alu_cb, alu_ext, alu_result} = alu_fn(alu_opcode, alu_acc, alu_ri);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        wptr = 0;
    endtask

    task automatic put(input logic [7:0] b);
        mem[wptr[7:0]] = b;
        wptr++;
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_ext = 8'h00;
        m_cb  = 1'b0;
        m_pc  = 8'h00;
        for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
    endtask

    task automatic model_exec(input logic [7:0] op);
        logic [16:0] o;
        logic [3:0]  hi;
        hi = op[7:4];
        o  = alu_fn(op, m_acc, m_r[op[3:0]]);
        if (hi inside {4'h1, 4'h2, 4'h5, 4'h6} ||
            (hi == 4'h0 && op[3:0] inside {4'h1, 4'h2, 4'h6, 4'h7})) begin
            m_acc = o[7:0];
            m_cb  = o[16];
        end else if (hi == 4'h3) begin
            m_acc = o[7:0];
            m_ext = o[15:8];
            m_cb  = o[16];
        end else if (hi == 4'h7) begin
            m_cb = o[16];
        end else if (hi == 4'h8) begin
            m_r[op[3:0]] = m_acc;
        end else if (hi == 4'h9) begin
            m_acc = m_r[op[3:0]];
        end
    endtask

    // Interprets the loaded program from address 0; returns cycles from first FETCH to HALT.
    task automatic model_run(output int cyc);
        logic [7:0] pc, op;
        pc  = 8'h00;
        cyc = 0;
        for (int k = 0; k < 1000; k++) begin
            op = mem[pc];
            pc = pc + 8'd1;
            if (op == 8'hFF) begin
                cyc += 2;
                break;
            end else if (op[7:4] == 4'hA) begin
                m_acc = mem[pc];
                pc    = pc + 8'd1;
                cyc  += 4;
            end else begin
                model_exec(op);
                cyc += 3;
            end
        end
        m_pc = pc;
    endtask

    task automatic run_prog(input string tag, output int n);
        int exp_cyc;
        model_run(exp_cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_at_fetch"}, busy, 1);
        check({tag, "_imem_rd_at_fetch"}, imem_rd, 1);
        n = 0;
        while (!halted && n < exp_cyc + 8) begin
            // Extra start pulses while busy must be ignored.
            start = (n < exp_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_cycles"}, n, exp_cyc);
        check({tag, "_halted"}, halted, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_acc"}, acc_out, m_acc);
        check({tag, "_ext"}, ext_out, m_ext);
        check({tag, "_cb"}, cb_out, m_cb);
        check({tag, "_pc"}, pc_out, m_pc);
    endtask

    int         cyc;
    int         n;
    int         len;
    logic [7:0] op;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_mem();
        model_reset();
        #22;
        check("rst_acc", acc_out, 0);
        check("rst_ext", ext_out, 0);
        check("rst_cb", cb_out, 0);
        check("rst_pc", pc_out, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_imem_rd", imem_rd, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        clear_mem();
        put(8'hA0); put(8'd10); put(8'h81); put(8'hA0); put(8'd20); put(8'h11); put(8'hFF);
        run_prog("add", cyc);
        check("add_acc30", acc_out, 30);
        check("add_cb0", cb_out, 0);
        check("add_cyc16", cyc, 16);

        clear_mem();
        put(8'hA0); put(8'd5); put(8'h83); put(8'hA0); put(8'd4); put(8'h33); put(8'hFF);
        run_prog("mul", cyc);
        check("mul_acc20", acc_out, 20);
        check("mul_ext0", ext_out, 0);

        clear_mem();
        put(8'hA0); put(8'd15); put(8'h83); put(8'hA0); put(8'd10); put(8'h73); put(8'hFF);
        run_prog("cmp", cyc);
        check("cmp_acc10", acc_out, 10);
        check("cmp_cb1", cb_out, 1);

        clear_mem();
        put(8'hA0); put(8'hFF); put(8'h06); put(8'hFF);
        run_prog("inc", cyc);
        check("inc_acc0", acc_out, 8'h00);

        clear_mem();
        put(8'hA0); put(8'h00); put(8'h07); put(8'hFF);
        run_prog("dec", cyc);
        check("dec_accff", acc_out, 8'hFF);

        clear_mem();
        put(8'hA0); put(8'h0F); put(8'h01); put(8'hFF);
        run_prog("lsl", cyc);
        check("lsl_acc1e", acc_out, 8'h1E);
        check("lsl_ext_kept", ext_out, 0);

        clear_mem();
        put(8'hA0); put(8'h33); put(8'h4A); put(8'hFF);
        run_prog("undef4a", cyc);

        clear_mem();
        put(8'h91); put(8'hFF);
        run_prog("rd_r1", cyc);
        check("rd_r1_acc10", acc_out, 10);

        // 255 NOPs, LDI at FF takes its immediate from 00; HLT patched in at 01 mid-run.
        clear_mem();
        mem[0] = 8'h4A;
        for (int i = 1; i < 255; i++) mem[i] = 8'h00;
        mem[255] = 8'hA0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!halted && n < 1000) begin
            if (pc_out == 8'h10) mem[1] = 8'hFF;
            @(posedge clk);
            #1;
            n++;
        end
        m_acc = 8'h4A;
        m_pc  = 8'h02;
        check("wrap_cycles", n, 255 * 3 + 4 + 2);
        check("wrap_acc", acc_out, m_acc);
        check("wrap_pc", pc_out, m_pc);
        check("wrap_cb", cb_out, m_cb);
        check("wrap_ext", ext_out, m_ext);

        clear_mem();
        put(8'hA0); put(8'h07); put(8'h11); put(8'hFF);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (alu_opcode !== 8'h11 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_exec_reached", alu_opcode, 8'h11);
        check("rst_exec_acc_pre", acc_out, 8'h07);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exec_acc", acc_out, 0);
        check("rst_exec_busy", busy, 0);
        check("rst_exec_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_exec_idle_busy", busy, 0);
        check("rst_exec_idle_acc", acc_out, 0);

        clear_mem();
        put(8'h91); put(8'hFF);
        run_prog("rd_r1_cleared", cyc);

        for (int t = 0; t < 25; t++) begin
            clear_mem();
            len = $urandom_range(3, 12);
            for (int k = 0; k < len; k++) begin
                op = 8'($urandom_range(0, 254));
                if ($urandom_range(0, 2) != 0) op = {hi_tab[$urandom_range(0, 9)], op[3:0]};
                put(op);
                if (op[7:4] == 4'hA) put(8'($urandom));
            end
            put(8'hFF);
            run_prog($sformatf("rand%0d", t), cyc);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
